// File: rtl/piso_serializer.sv
// Purpose: parallel-in serial-out transmitter; one word in over valid/ready, one bit out per shift_en strobe, frame marker on bit 0.
// Latency: first bit on sout 1 cycle after the load handshake; back-to-back words stream with no idle gap.
// Backpressure: load_ready only in IDLE or while the last bit is being consumed; shift_en=0 freezes every bit-path register.
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           state_q,       state_d;
   logic [WIDTH-1:0] shreg_q,       shreg_d;
   logic [CNT_W-1:0] cnt_q,         cnt_d;
   logic             sout_q,        sout_d;
   logic             sout_valid_q,  sout_valid_d;
   logic             frame_start_q, frame_start_d;

   logic             handshake;
   logic             last_bit;
   logic [WIDTH-1:0] shreg_adv;

   // Bit that goes on the wire first for a given word, in the configured order.
   function automatic logic lead_bit(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) begin
         return w[WIDTH-1];
      end
      return w[0];
   endfunction

   // Drop the bit just sent so the next one moves into the lead position.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) begin
         return w << 1;
      end
      return w >> 1;
   endfunction

   // Ready in IDLE, or when the last bit is consumed this edge so the next word follows without a gap.
   always_comb begin
      last_bit   = (cnt_q == CNT_LAST);
      load_ready = (state_q == ST_IDLE) ||
                   ((state_q == ST_SHIFT) && last_bit && shift_en);
      handshake  = load_valid && load_ready;
      busy       = (state_q == ST_SHIFT);
      shreg_adv  = advance(shreg_q);
   end

   // Next-state and bit-path update; everything holds unless a handshake or an enabled shift occurs.
   always_comb begin
      state_d       = state_q;
      shreg_d       = shreg_q;
      cnt_d         = cnt_q;
      sout_d        = sout_q;
      sout_valid_d  = sout_valid_q;
      frame_start_d = frame_start_q;

      unique case (state_q)
         ST_IDLE: begin
            // shift_en has no meaning until a word is in flight
            if (handshake) begin
               state_d       = ST_SHIFT;
               shreg_d       = load_data;
               cnt_d         = '0;
               sout_d        = lead_bit(load_data);
               sout_valid_d  = 1'b1;
               frame_start_d = 1'b1;
            end
         end

         ST_SHIFT: begin
            if (shift_en) begin
               if (!last_bit) begin
                  shreg_d       = shreg_adv;
                  cnt_d         = cnt_q + 1'b1;
                  sout_d        = lead_bit(shreg_adv);
                  sout_valid_d  = 1'b1;
                  frame_start_d = 1'b0;
               end else if (handshake) begin
                  // next word's first bit replaces the last bit directly
                  shreg_d       = load_data;
                  cnt_d         = '0;
                  sout_d        = lead_bit(load_data);
                  sout_valid_d  = 1'b1;
                  frame_start_d = 1'b1;
               end else begin
                  state_d       = ST_IDLE;
                  shreg_d       = '0;
                  cnt_d         = '0;
                  sout_d        = 1'b0;
                  sout_valid_d  = 1'b0;
                  frame_start_d = 1'b0;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and bit-path registers; reset abandons any word in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         shreg_q       <= '0;
         cnt_q         <= '0;
         sout_q        <= 1'b0;
         sout_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         shreg_q       <= shreg_d;
         cnt_q         <= cnt_d;
         sout_q        <= sout_d;
         sout_valid_q  <= sout_valid_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign sout        = sout_q;
   assign sout_valid  = sout_valid_q;
   assign frame_start = frame_start_q;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out transmitter. It is the sending end for the team's serial-in shift-register chains. It accepts a WIDTH-bit word over a valid/ready handshake and shifts the word out one bit per enabled clock, with a frame marker on the first bit. Back-to-back words stream with no idle gap, so a downstream SISO/SIPO chain sees a continuous bit stream.

Parameters:
WIDTH, 8, word width in bits; must be 2 or more.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
load_valid  input  1  upstream has a word on load_data.
load_data  input  WIDTH  word to serialize; sampled only on handshake.
load_ready  output  1  serializer can accept a word this cycle.
shift_en  input  1  bit-advance enable (downstream bit strobe); 0 stalls the shifter.
sout  output  1  serial data bit (registered).
sout_valid  output  1  sout carries a valid data bit this cycle (registered).
frame_start  output  1  high with the first bit of each word (registered).
busy  output  1  a word is in flight (state SHIFT).

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state = IDLE, shift register = 0, bit counter = 0;
  - sout = 0, sout_valid = 0, frame_start = 0, busy = 0.
  - load_ready is combinational and equals 1 while in IDLE after reset.
- Reset mid-word: the word is discarded with no partial completion; outputs take their reset values immediately.
- States: IDLE, SHIFT. Bit counter width is $clog2(WIDTH).
- load_ready (combinational) = (state == IDLE) OR (state == SHIFT AND cnt == WIDTH-1 AND shift_en).
- Handshake occurs when load_valid AND load_ready are high at a rising edge.
  - load_data is captured into the shift register.
  - cnt is set to 0 and state goes to SHIFT.
  - The first bit appears on sout in the following cycle, with sout_valid = 1 and frame_start = 1. Latency is 1 cycle from the handshake edge to the first bit.
- In SHIFT with shift_en = 1 at an edge:
  - If cnt < WIDTH-1: advance to the next bit in MSB_FIRST order, cnt increments, frame_start = 0, sout_valid stays 1.
  - If cnt == WIDTH-1 with a handshake in the same edge: load the new word and set cnt = 0. sout shows the new word's first bit with frame_start = 1, so there is no gap cycle.
  - If cnt == WIDTH-1 with no handshake: go to IDLE, sout_valid = 0, sout = 0, frame_start = 0.
- In SHIFT with shift_en = 0: shift register, cnt, sout, sout_valid and frame_start all hold their values.
  - Each bit stays valid until it is consumed by an edge with shift_en = 1.
  - frame_start stays high across a stall on bit 0.
- In IDLE, shift_en is ignored.
- load_valid while load_ready = 0: no capture and no effect. Upstream must hold load_valid and load_data until the handshake.
- busy = (state == SHIFT).
- Each word yields exactly WIDTH cycles in which sout_valid = 1 and shift_en = 1.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, shift_en tied 1; load 0xA5 in IDLE -> from the next cycle sout = 1,0,1,0,0,1,0,1 with sout_valid high for 8 cycles and frame_start high only on the first. Then sout_valid = 0 and load_ready = 1.
2. Back-to-back 0xA5 then 0x3C, with load_valid held through the last bit of 0xA5 -> 16 contiguous valid bits 10100101 00111100, frame_start on bits 0 and 8, no idle cycle.
3. shift_en low for 3 cycles after bit 2 of 0xF0 -> sout holds bit 2 (=1) for 4 cycles, then the stream resumes; total of 8 bits with shift_en=1 and correct order.
4. MSB_FIRST=0; load 0x01 -> sout = 1,0,0,0,0,0,0,0.
5. load_valid with 0xFF while busy at bit 3 of 0x00 -> load_ready = 0, and 0x00 completes unaltered. The 0xFF handshake occurs on the last bit only.
6. Assert rst_n low at bit 4 of 0xAA -> sout, sout_valid, frame_start and busy go to 0 immediately. After release, load_ready = 1 and a fresh load of 0x55 serializes correctly.
